// File: rtl/l2_cache_nway_wb.sv
// l2_cache_nway_wb
//   N-way set-associative, write-back, write-allocate L2 cache between an L1
//   block port and a block-wide main memory port. It handles one request at a
//   time, and requests that arrive while busy are ignored. Victim selection takes
//   the lowest invalid way first. When every way is valid it uses true LRU
//   (REPL_POLICY=0) or a per-set round-robin pointer (REPL_POLICY=1). A dirty
//   victim is written back before the fill.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   l2_cache_addr       byte address of the request (offset bits ignored)
//   l2_cache_data_in    full-block write data, word j at [j*DW +: DW]
//   l2_cache_read/write request strobes, sampled only while idle (read wins)
//   l2_cache_data_out   response block, held until the next response
//   l2_cache_ready      one-cycle completion pulse
//   l2_hit              hit flag, meaningful only with ready
//   l2_cache_busy       high whenever a request is in flight
//   mem_addr            block-aligned memory address for fill / writeback
//   mem_data_out        victim block during writeback
//   mem_data_in         fill block from memory
//   mem_read/mem_write  fill / writeback request, held until mem_ready
//   mem_ready           memory completion
//
// Handshake: a memory request (mem_read or mem_write) stays asserted with
// stable address and data until the cycle in which mem_ready is sampled high.
// The request drops on the following cycle. l2_cache_ready is high for exactly
// one cycle (the RESPOND state), and l2_cache_data_out and l2_hit are valid in
// that cycle.
module l2_cache_nway_wb #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 16,
  parameter int REPL_POLICY = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDR_WIDTH-1:0]             l2_cache_addr,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_cache_data_in,
  input  logic                              l2_cache_read,
  input  logic                              l2_cache_write,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_cache_data_out,
  output logic                              l2_cache_ready,
  output logic                              l2_hit,
  output logic                              l2_cache_busy,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] mem_data_in,
  output logic                              mem_read,
  output logic                              mem_write,
  input  logic                              mem_ready
);

  localparam int BLK_W = BLOCK_WORDS * DATA_WIDTH;
  localparam int OFS   = $clog2(BLK_W / 8);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - OFS - IDX_W;
  localparam int WAY_W = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL,
    S_RESPOND
  } state_t;

  state_t state_q, state_d;

  // Cache arrays. Tag and data need no reset because valid gates them.
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]    data_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
  logic [WAY_W-1:0]    age_q    [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    rr_q     [NUM_SETS];

  // Latched request and per-transaction context
  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic [BLK_W-1:0] req_data_q;
  logic             req_write_q;
  logic             hit_q;
  logic [WAY_W-1:0] victim_q;
  logic [TAG_W-1:0] victim_tag_q;
  logic [BLK_W-1:0] victim_data_q;
  logic [BLK_W-1:0] data_out_q;

  // Offset bits select nothing in a block-wide interface.
  logic unused_ofs;
  assign unused_ofs = ^l2_cache_addr[OFS-1:0];

  // Lookup over the latched set
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim_way;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    // Walk downward so that the lowest matching index is the last one assigned.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx_q][w] && (tag_mem[req_idx_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      // Ages in a set always form a permutation, so the maximum age is NUM_WAYS-1.
      if (age_q[req_idx_q][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
    end
    if (inv_found)              victim_way = inv_way;
    else if (REPL_POLICY == 1)  victim_way = rr_q[req_idx_q];
    else                        victim_way = lru_way;
  end

  // Action strobes produced by the FSM
  logic             arr_we;
  logic [WAY_W-1:0] arr_way;
  logic [BLK_W-1:0] arr_data;
  logic             arr_dirty;
  logic             touch_en;
  logic [WAY_W-1:0] touch_way;
  logic             clean_en;
  logic             rr_adv;
  logic             out_load;
  logic [BLK_W-1:0] out_data;

  always_comb begin
    state_d   = state_q;
    arr_we    = 1'b0;
    arr_way   = '0;
    arr_data  = '0;
    arr_dirty = 1'b0;
    touch_en  = 1'b0;
    touch_way = '0;
    clean_en  = 1'b0;
    rr_adv    = 1'b0;
    out_load  = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (l2_cache_read || l2_cache_write) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          touch_en  = 1'b1;
          touch_way = hit_way;
          out_load  = 1'b1;
          out_data  = req_write_q ? req_data_q : data_mem[req_idx_q][hit_way];
          if (req_write_q) begin
            arr_we    = 1'b1;
            arr_way   = hit_way;
            arr_data  = req_data_q;
            arr_dirty = 1'b1;
          end
          state_d = S_RESPOND;
        end else begin
          // The pointer moves only when a valid line is evicted.
          rr_adv = (REPL_POLICY == 1) && !inv_found;
          if (valid_q[req_idx_q][victim_way] && dirty_q[req_idx_q][victim_way]) begin
            state_d = S_WRITEBACK;
          end else if (!req_write_q) begin
            state_d = S_FILL;
          end else begin
            // A full-block write allocates without fetching the old contents.
            arr_we    = 1'b1;
            arr_way   = victim_way;
            arr_data  = req_data_q;
            arr_dirty = 1'b1;
            touch_en  = 1'b1;
            touch_way = victim_way;
            out_load  = 1'b1;
            out_data  = req_data_q;
            state_d   = S_RESPOND;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          clean_en = 1'b1;
          if (req_write_q) begin
            arr_we    = 1'b1;
            arr_way   = victim_q;
            arr_data  = req_data_q;
            arr_dirty = 1'b1;
            touch_en  = 1'b1;
            touch_way = victim_q;
            out_load  = 1'b1;
            out_data  = req_data_q;
            state_d   = S_RESPOND;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          arr_we    = 1'b1;
          arr_way   = victim_q;
          arr_data  = mem_data_in;
          arr_dirty = 1'b0;
          touch_en  = 1'b1;
          touch_way = victim_q;
          out_load  = 1'b1;
          out_data  = mem_data_in;
          state_d   = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag_q     <= '0;
      req_idx_q     <= '0;
      req_data_q    <= '0;
      req_write_q   <= 1'b0;
      hit_q         <= 1'b0;
      victim_q      <= '0;
      victim_tag_q  <= '0;
      victim_data_q <= '0;
      data_out_q    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (state_q == S_IDLE && (l2_cache_read || l2_cache_write)) begin
        req_tag_q   <= l2_cache_addr[ADDR_WIDTH-1 -: TAG_W];
        req_idx_q   <= l2_cache_addr[OFS +: IDX_W];
        req_data_q  <= l2_cache_data_in;
        req_write_q <= !l2_cache_read;
      end
      if (state_q == S_LOOKUP) begin
        hit_q         <= hit;
        victim_q      <= victim_way;
        victim_tag_q  <= tag_mem[req_idx_q][victim_way];
        victim_data_q <= data_mem[req_idx_q][victim_way];
      end
      // NUM_WAYS is a power of two, so the pointer wraps to zero on its own.
      if (rr_adv) rr_q[req_idx_q] <= rr_q[req_idx_q] + 1'b1;
      if (clean_en) dirty_q[req_idx_q][victim_q] <= 1'b0;
      // This comes after the clean so that a write-allocate following a writeback ends dirty.
      if (arr_we) begin
        valid_q[req_idx_q][arr_way] <= 1'b1;
        dirty_q[req_idx_q][arr_way] <= arr_dirty;
      end
      if (touch_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == touch_way)
            age_q[req_idx_q][w] <= '0;
          else if (age_q[req_idx_q][w] < age_q[req_idx_q][touch_way])
            age_q[req_idx_q][w] <= age_q[req_idx_q][w] + 1'b1;
        end
      end
      if (out_load) data_out_q <= out_data;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_mem[req_idx_q][arr_way] <= arr_data;
      tag_mem[req_idx_q][arr_way]  <= req_tag_q;
    end
  end

  assign l2_cache_busy     = (state_q != S_IDLE);
  assign l2_cache_ready    = (state_q == S_RESPOND);
  assign l2_hit            = l2_cache_ready && hit_q;
  assign l2_cache_data_out = data_out_q;
  assign mem_read          = (state_q == S_FILL);
  assign mem_write         = (state_q == S_WRITEBACK);
  assign mem_data_out      = mem_write ? victim_data_q : '0;
  assign mem_addr          = mem_write ? {victim_tag_q, req_idx_q, {OFS{1'b0}}} :
                             mem_read  ? {req_tag_q, req_idx_q, {OFS{1'b0}}} : '0;

endmodule

// File: tb/tb_l2_cache_nway_wb.sv
// Bench for l2_cache_nway_wb. One LRU instance and one round-robin instance
// take turns on a shared stimulus bus. A per-set recency list and a pointer
// model the cache contents, victims and memory traffic.
module tb_l2_cache_nway_wb;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NS  = 16;
  localparam int NW  = 4;
  localparam int BW  = 16;
  localparam int BLK = BW * DW;
  localparam int TW  = 22;
  localparam int CW  = AW + BLK + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]  addr;
  logic [BLK-1:0] wdata;
  logic           rd, wr, sel;
  logic [BLK-1:0] mem_din;
  logic           mem_rdy;
  bit             hold_mem;

  logic [BLK-1:0] dout0, dout1, mdout0, mdout1;
  logic [AW-1:0]  maddr0, maddr1;
  logic rdy0, rdy1, hit0, hit1, busy0, busy1, mrd0, mrd1, mwr0, mwr1;

  l2_cache_nway_wb #(.REPL_POLICY(0)) u_lru (
    .clk(clk), .rst_n(rst_n), .l2_cache_addr(addr), .l2_cache_data_in(wdata),
    .l2_cache_read(rd & ~sel), .l2_cache_write(wr & ~sel),
    .l2_cache_data_out(dout0), .l2_cache_ready(rdy0), .l2_hit(hit0), .l2_cache_busy(busy0),
    .mem_addr(maddr0), .mem_data_out(mdout0), .mem_data_in(mem_din),
    .mem_read(mrd0), .mem_write(mwr0), .mem_ready(mem_rdy & ~sel)
  );

  l2_cache_nway_wb #(.REPL_POLICY(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .l2_cache_addr(addr), .l2_cache_data_in(wdata),
    .l2_cache_read(rd & sel), .l2_cache_write(wr & sel),
    .l2_cache_data_out(dout1), .l2_cache_ready(rdy1), .l2_hit(hit1), .l2_cache_busy(busy1),
    .mem_addr(maddr1), .mem_data_out(mdout1), .mem_data_in(mem_din),
    .mem_read(mrd1), .mem_write(mwr1), .mem_ready(mem_rdy & sel)
  );

  logic [BLK-1:0] c_dout, c_mdout;
  logic [AW-1:0]  c_maddr;
  logic c_ready, c_hit, c_busy, c_mrd, c_mwr;
  assign c_dout  = sel ? dout1  : dout0;
  assign c_mdout = sel ? mdout1 : mdout0;
  assign c_maddr = sel ? maddr1 : maddr0;
  assign c_ready = sel ? rdy1   : rdy0;
  assign c_hit   = sel ? hit1   : hit0;
  assign c_busy  = sel ? busy1  : busy0;
  assign c_mrd   = sel ? mrd1   : mrd0;
  assign c_mwr   = sel ? mwr1   : mwr0;

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  logic [BLK:0]  exp_q[$];      // {hit, block}
  logic [CW-1:0] exp_mem_q[$];  // {is_write, addr, data (0 for fills)}

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ---------------- memory contents ----------------
  // Untouched memory blocks hold word j = ((block_addr >> 6) << 12) + j.
  function automatic logic [BLK-1:0] pat(input logic [AW-1:0] blk);
    logic [BLK-1:0] v;
    for (int j = 0; j < BW; j++) v[j*DW +: DW] = ((blk >> 6) << 12) + j;
    return v;
  endfunction

  function automatic logic [BLK-1:0] wpat(input logic [DW-1:0] base);
    logic [BLK-1:0] v;
    for (int j = 0; j < BW; j++) v[j*DW +: DW] = base + j;
    return v;
  endfunction

  logic [BLK-1:0] env_mem [logic [AW-1:0]];  // what the DUT actually wrote back
  logic [BLK-1:0] ref_mem [logic [AW-1:0]];  // what the model says was written back

  // ---------------- reference model ----------------
  typedef struct packed {
    logic           valid;
    logic           dirty;
    logic [TW-1:0]  tag;
    logic [BLK-1:0] data;
  } line_t;

  line_t cl [NS][NW];
  int    recency_q [NS][$];  // front = most recently used way
  int    rr_ptr [NS];
  int    pol;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      recency_q[s] = {};
      for (int w = 0; w < NW; w++) begin
        cl[s][w] = '0;
        recency_q[s].push_back(w);
      end
      rr_ptr[s] = 0;
    end
    exp_q.delete();
    exp_mem_q.delete();
  endtask

  task automatic model_access(input logic [AW-1:0] a, input bit is_w, input logic [BLK-1:0] d);
    int s, way, v;
    logic [TW-1:0] t;
    logic [AW-1:0] blk, vblk;
    s = int'(a[9:6]);
    t = a[31:10];
    blk = {a[31:6], 6'b0};
    way = -1;
    for (int w = 0; w < NW; w++) if (cl[s][w].valid && cl[s][w].tag == t) way = w;
    if (way >= 0) begin
      if (is_w) begin
        cl[s][way].data  = d;
        cl[s][way].dirty = 1'b1;
      end
      exp_q.push_back({1'b1, cl[s][way].data});
    end else begin
      v = -1;
      for (int w = NW - 1; w >= 0; w--) if (!cl[s][w].valid) v = w;
      if (v < 0) begin
        if (pol == 0) v = recency_q[s][recency_q[s].size() - 1];
        else begin
          v = rr_ptr[s];
          rr_ptr[s] = (rr_ptr[s] + 1) % NW;
        end
        if (cl[s][v].dirty) begin
          vblk = {cl[s][v].tag, 4'(s), 6'b0};
          exp_mem_q.push_back({1'b1, vblk, cl[s][v].data});
          ref_mem[vblk] = cl[s][v].data;
        end
      end
      cl[s][v].valid = 1'b1;
      cl[s][v].tag   = t;
      if (is_w) begin
        cl[s][v].dirty = 1'b1;
        cl[s][v].data  = d;
      end else begin
        exp_mem_q.push_back({1'b0, blk, {BLK{1'b0}}});
        cl[s][v].dirty = 1'b0;
        cl[s][v].data  = ref_mem.exists(blk) ? ref_mem[blk] : pat(blk);
      end
      exp_q.push_back({1'b0, cl[s][v].data});
      way = v;
    end
    for (int i = 0; i < recency_q[s].size(); i++) begin
      if (recency_q[s][i] == way) begin
        recency_q[s].delete(i);
        break;
      end
    end
    recency_q[s].push_front(way);
  endtask

  // ---------------- memory responder / monitor ----------------
  initial begin
    int wait_cnt;
    logic [CW-1:0] e;
    wait_cnt = 3;
    mem_rdy  = 1'b0;
    mem_din  = '0;
    forever begin
      @(negedge clk);
      if (mem_rdy) begin
        mem_rdy = 1'b0;
      end else if (rst_n && !hold_mem && (c_mrd || c_mwr)) begin
        if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          if (exp_mem_q.size() == 0) begin
            note_fail("unexpected_mem_op");
          end else begin
            e = exp_mem_q.pop_front();
            chk("mem_op", {c_mwr, c_maddr, (c_mwr ? c_mdout : {BLK{1'b0}})}, e);
          end
          if (c_mwr) env_mem[c_maddr] = c_mdout;
          else mem_din = env_mem.exists(c_maddr) ? env_mem[c_maddr] : pat(c_maddr);
          mem_rdy  = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [BLK:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && c_busy) begin
        chk("mem_rd_wr_exclusive", {CW{1'b0}} | (c_mrd & c_mwr), '0);
        chk("hit_without_ready", {CW{1'b0}} | (c_hit & ~c_ready), '0);
      end
      if (rst_n && c_ready) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_ready");
        end else begin
          e = exp_q.pop_front();
          chk("response", {c_hit, c_dout}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [AW-1:0] a, input bit r, input bit w, input logic [BLK-1:0] d);
    bit done;
    model_access(a, !r, d);
    @(negedge clk);
    addr = a; wdata = d; rd = r; wr = w;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (c_ready) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) note_fail("request_timeout");
  endtask

  task automatic apply_reset(input int p);
    @(negedge clk);
    rst_n = 1'b0;
    sel = p[0];
    pol = p;
    hold_mem = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0]  a;
      logic [BLK-1:0] d;
      int k;
      a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
      for (int j = 0; j < BW; j++) d[j*DW +: DW] = $urandom;
      k = $urandom_range(0, 9);
      if (k < 5)      do_req(a, 1'b1, 1'b0, d);
      else if (k < 9) do_req(a, 1'b0, 1'b1, d);
      else            do_req(a, 1'b1, 1'b1, d);
    end
  endtask

  task automatic reset_during_fill();
    bit seen;
    apply_reset(0);
    hold_mem = 1'b1;
    model_access(32'h80, 1'b0, '0);
    @(negedge clk);
    addr = 32'h80; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (c_mrd) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) note_fail("fill_not_started");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_read", {CW{1'b0}} | c_mrd, '0);
    chk("rst_mid_mem_write", {CW{1'b0}} | c_mwr, '0);
    chk("rst_mid_busy", {CW{1'b0}} | c_busy, '0);
    chk("rst_mid_ready", {CW{1'b0}} | c_ready, '0);
    model_reset();
    hold_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(32'h40, 1'b1, 1'b0, '0);
    do_req(32'h80, 1'b1, 1'b0, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    sel = 1'b0; pol = 0; hold_mem = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", {CW{1'b0}} | c_ready, '0);
    chk("rst_hit", {CW{1'b0}} | c_hit, '0);
    chk("rst_busy", {CW{1'b0}} | c_busy, '0);
    chk("rst_mem_rw", {CW{1'b0}} | {c_mrd, c_mwr}, '0);
    chk("rst_mem_addr", {CW{1'b0}} | c_maddr, '0);
    chk("rst_data_out", {CW{1'b0}} | c_dout, '0);
    rst_n = 1'b1;

    // cold read, re-read, write hit, cold write-allocate
    do_req(32'h40, 1'b1, 1'b0, '0);
    do_req(32'h40, 1'b1, 1'b0, '0);
    do_req(32'h40, 1'b0, 1'b1, wpat(32'hA000));
    do_req(32'h40, 1'b1, 1'b0, '0);
    do_req(32'h2080, 1'b0, 1'b1, wpat(32'hB000));
    do_req(32'h2080, 1'b1, 1'b0, '0);

    // LRU eviction in set 1, then force the dirty line out
    apply_reset(0);
    do_req(32'h040, 1'b1, 1'b0, '0);
    do_req(32'h440, 1'b1, 1'b0, '0);
    do_req(32'h840, 1'b1, 1'b0, '0);
    do_req(32'hC40, 1'b1, 1'b0, '0);
    do_req(32'h440, 1'b0, 1'b1, wpat(32'hC000));
    do_req(32'h040, 1'b1, 1'b0, '0);
    do_req(32'h1040, 1'b1, 1'b0, '0);
    do_req(32'hC40, 1'b1, 1'b0, '0);
    do_req(32'h1840, 1'b1, 1'b0, '0);
    random_phase(200);

    reset_during_fill();

    // round-robin instance
    apply_reset(1);
    do_req(32'h040, 1'b1, 1'b0, '0);
    do_req(32'h440, 1'b1, 1'b0, '0);
    do_req(32'h840, 1'b1, 1'b0, '0);
    do_req(32'hC40, 1'b1, 1'b0, '0);
    do_req(32'h1040, 1'b1, 1'b0, '0);
    do_req(32'h1440, 1'b1, 1'b0, '0);
    random_phase(200);

    repeat (5) @(negedge clk);
    chk("leftover_responses", CW'(exp_q.size()), '0);
    chk("leftover_mem_ops", CW'(exp_mem_q.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
